// File: rtl/vga_box_renderer_pkg.sv
// Shared constants and types for the bouncing-box pixel stage: visible area,
// box geometry, colours, frame FSM states and axis direction.
package vga_box_renderer_pkg;

  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] V_VIS = 10'd480;
  localparam logic [9:0] BOX_W = 10'd32;
  localparam logic [9:0] BOX_H = 10'd32;
  localparam logic [9:0] STEP  = 10'd2;
  localparam logic [9:0] X0    = 10'd0;
  localparam logic [9:0] Y0    = 10'd0;

  // 3-3-2 RGB: {R[2:0], G[2:0], B[1:0]}
  localparam logic [7:0] BOX_COLOR = 8'hE0;
  localparam logic [7:0] BG_COLOR  = 8'h03;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_UPDATE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/vga_box_renderer_if.sv
// Raster timing bundle produced by the VGA timer and consumed by pixel stages.
interface vga_box_renderer_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       bright;
  logic [9:0] hcount;
  logic [9:0] vcount;

  modport master (output hsync_in, vsync_in, bright, hcount, vcount);
  modport slave  (input  hsync_in, vsync_in, bright, hcount, vcount);
endinterface

// File: rtl/vga_box_renderer_bounce_axis.sv
// One axis of the bouncing box: steps by STEP when enabled, clamping to
// [0, LIM] and reversing direction on contact with either wall.
module vga_box_renderer_bounce_axis
  import vga_box_renderer_pkg::*;
#(
  parameter logic [9:0] LIM  = 10'd608,
  parameter logic [9:0] STEP = 10'd2,
  parameter logic [9:0] P0   = 10'd0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       step_en,
  output logic [9:0] pos,
  output dir_t       dir
);

  // Widened so pos+STEP near the limit cannot wrap and miss the wall.
  logic [10:0] pos_fwd;
  assign pos_fwd = {1'b0, pos} + {1'b0, STEP};

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values, regardless of the order of always blocks.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      pos <= P0;
      dir <= DIR_POS;
    end else if (step_en) begin
      if (dir == DIR_POS) begin
        if (pos_fwd >= {1'b0, LIM}) begin
          pos <= LIM;
          dir <= DIR_NEG;
        end else begin
          pos <= pos_fwd[9:0];
        end
      end else begin
        if (pos <= STEP) begin
          pos <= '0;
          dir <= DIR_POS;
        end else begin
          pos <= pos - STEP;
        end
      end
    end
  end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage behind the VGA timer: draws a bouncing solid box with a 2-cycle
// pipeline and re-aligns hsync/vsync to the colour output.
module vga_box_renderer
  import vga_box_renderer_pkg::*;
(
  input  logic                      clk,
  input  logic                      clear,
  vga_box_renderer_if.slave         vin,
  input  logic                      pause,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [7:0]                rgb,
  output logic                      frame_tick
);

  state_t     state;
  logic [9:0] x_pos, y_pos;
  dir_t       x_dir, y_dir;
  logic       step_en;

  assign step_en = (state == ST_UPDATE) && !pause;

  vga_box_renderer_bounce_axis #(.LIM(H_VIS - BOX_W), .STEP(STEP), .P0(X0)) u_x_axis (
    .clk(clk), .clear(clear), .step_en(step_en), .pos(x_pos), .dir(x_dir)
  );

  vga_box_renderer_bounce_axis #(.LIM(V_VIS - BOX_H), .STEP(STEP), .P0(Y0)) u_y_axis (
    .clk(clk), .clear(clear), .step_en(step_en), .pos(y_pos), .dir(y_dir)
  );

  // 11-bit compares so the right/bottom edge never wraps.
  logic [10:0] hc, vc, x_lo, y_lo, x_hi, y_hi;
  logic        in_box;

  assign hc     = {1'b0, vin.hcount};
  assign vc     = {1'b0, vin.vcount};
  assign x_lo   = {1'b0, x_pos};
  assign y_lo   = {1'b0, y_pos};
  assign x_hi   = x_lo + {1'b0, BOX_W};
  assign y_hi   = y_lo + {1'b0, BOX_H};
  assign in_box = (hc >= x_lo) && (hc < x_hi) && (vc >= y_lo) && (vc < y_hi);

  logic bright_d1, in_box_d1, hsync_d1, vsync_d1;

  // Syncs idle high, so reset them to 1 to avoid a spurious sync pulse.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      bright_d1 <= 1'b0;
      in_box_d1 <= 1'b0;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      bright_d1 <= vin.bright;
      in_box_d1 <= in_box;
      hsync_d1  <= vin.hsync_in;
      vsync_d1  <= vin.vsync_in;
      rgb       <= !bright_d1 ? 8'h00 : (in_box_d1 ? BOX_COLOR : BG_COLOR);
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
    end
  end

  // Position moves only while the raster is in vertical blanking.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= ST_ACTIVE;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        ST_ACTIVE: begin
          if (vin.vcount == V_VIS && vin.hcount == 10'd0) begin
            state      <= ST_UPDATE;
            frame_tick <= 1'b1;
          end
        end
        ST_UPDATE: state <= ST_BLANK;
        ST_BLANK: begin
          if (vin.vcount == 10'd0) state <= ST_ACTIVE;
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

endmodule
